qar_mem_arbiter: RTL and testbench
==================================

QAR_MEM_ARBITER -- requirements
Module: qar_mem_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, maximum consecutive data-port grants while a fetch request waits (range 1-15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 if_req  input  1  instruction-fetch request (read-only port).
REQ-005 if_addr  input  32  fetch address.
REQ-006 if_gnt  output  1  fetch request accepted this cycle.
REQ-007 if_rvalid  output  1  one-cycle pulse: fetch data returned.
REQ-008 if_rdata  output  32  fetch read data, valid with if_rvalid.
REQ-009 d_req  input  1  data-access request.
REQ-010 d_addr, d_wdata  input  32 each  data address, write data.
REQ-011 d_we  input  1  1 = write, 0 = read.
REQ-012 d_gnt  output  1  data request accepted this cycle.
REQ-013 d_rvalid  output  1  one-cycle pulse: read data returned or write acknowledged.
REQ-014 d_rdata  output  32  data read data, valid with d_rvalid.
REQ-015 mem_valid  output  1  transaction presented to memory.
REQ-016 mem_addr, mem_wdata  output  32 each  memory address, write data.
REQ-017 mem_we  output  1  memory write enable, meaningful only while mem_valid=1.
REQ-018 mem_ready  input  1  memory completes the current transaction this cycle; mem_rdata valid.
REQ-019 mem_rdata  input  32  memory read data.

Function
REQ-020 FSM shall have exactly two states: IDLE and BUSY.
REQ-021 In IDLE with at least one req high, the arbiter shall select one winner and assert that port's gnt combinationally in the same cycle; the other gnt shall stay 0.
REQ-022 On grant, the arbiter shall register winner id, addr, wdata (data port only) and we (0 for fetch) and shall enter BUSY on the next edge.
REQ-023 Requesters shall hold req and payload stable until gnt; the arbiter samples the payload only in the gnt cycle.
REQ-024 In BUSY, mem_valid shall be 1, with mem_addr/mem_wdata/mem_we driven from the registered values and stable until mem_ready=1.
REQ-025 In BUSY on a mem_ready=1 edge, the arbiter shall return to IDLE and, in the next cycle, pulse the owner's rvalid for exactly one cycle.
REQ-026 Read data presented with rvalid shall be mem_rdata registered at mem_ready; for a write, d_rvalid shall pulse with d_rdata=0.
REQ-027 Latency: gnt at cycle T; mem_valid from T+1; mem_ready at T+k (k>=1); rvalid at T+k+1; a new gnt is permitted in cycle T+k+1.
REQ-028 In IDLE, mem_valid shall be 0 and mem_ready shall be ignored; gnt shall be 0 in BUSY.
REQ-029 Priority: data port wins simultaneous requests unless the starvation counter equals STARVE_LIMIT, in which case fetch wins.
REQ-030 The starvation counter (4 bits) shall increment on each data grant made while if_req=1, clear on each fetch grant, clear on any arbitration cycle with if_req=0, and saturate at STARVE_LIMIT.
REQ-031 A single requester shall always be granted on its first IDLE cycle, regardless of counter value.
REQ-032 rdata outputs shall hold their last value when rvalid=0; addresses pass through unmodified, with no alignment checks.

Reset
REQ-033 With rst=1 at an edge: state=IDLE, starvation counter=0, mem_valid=0, mem_we=0, if_rvalid=0, d_rvalid=0, mem_addr=mem_wdata=if_rdata=d_rdata=0.
REQ-034 Reset during BUSY shall abandon the in-flight transaction: no rvalid shall follow, and a later mem_ready shall be ignored.
REQ-035 gnt outputs shall be 0 while rst=1.

Verification
REQ-036 Single fetch: if_req=1, if_addr=0x100 at T0; mem_ready at T2 with mem_rdata=0xDEADBEEF -> if_gnt at T0; mem_valid=1, mem_addr=0x100, mem_we=0 at T1-T2; if_rvalid=1, if_rdata=0xDEADBEEF at T3 only.
REQ-037 Simultaneous: if_req and d_req (read, 0x200) both high at T0; memory always ready -> d_gnt at T0, d_rvalid at T2, if_gnt at T2, if_rvalid at T4.
REQ-038 Starvation, STARVE_LIMIT=4: d_req and if_req held high; mem_ready=1 always -> four d_gnt, then if_gnt on the fifth grant; the counter clears and the pattern repeats.
REQ-039 Write: d_we=1, d_addr=0x40, d_wdata=0x12345678, mem_ready delayed 3 cycles -> mem_we=1 and mem_wdata=0x12345678 stable for 3 cycles; d_rvalid pulse with d_rdata=0; if_rvalid=0 throughout.
REQ-040 Reset mid-op: rst=1 for one cycle while in BUSY, then mem_ready=1 -> mem_valid=0 the cycle after reset; no rvalid; a new if_req is then granted normally.
REQ-041 Stray mem_ready=1 in IDLE with no requests -> no rvalid, no state change, mem_valid stays 0.

Source files
------------

// File: rtl/qar_mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter onto a single-outstanding memory bus.
// Data port has priority; a starvation counter forces a fetch grant after STARVE_LIMIT data wins.
module qar_mem_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   input  logic        d_req,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic        d_we,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic        mem_valid,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_we,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata
);
   localparam int unsigned CW = 4;
   localparam int unsigned DW = 32;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t        state_q;
   logic          owner_d_q;
   logic [CW-1:0] starve_q;
   logic [DW-1:0] mem_addr_q;
   logic [DW-1:0] mem_wdata_q;
   logic [DW-1:0] if_rdata_q;
   logic [DW-1:0] d_rdata_q;
   logic          mem_we_q;
   logic          if_rvalid_q;
   logic          d_rvalid_q;
   logic          arb_c;
   logic          fetch_wins_c;

   // Grants are combinational so the winner sees acceptance in its request cycle.
   assign arb_c        = (state_q == IDLE) && !rst;
   assign fetch_wins_c = if_req && (!d_req || (starve_q == CW'(STARVE_LIMIT)));
   assign if_gnt       = arb_c && fetch_wins_c;
   assign d_gnt        = arb_c && d_req && !fetch_wins_c;

   assign mem_valid = (state_q == BUSY);
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_we    = mem_we_q;
   assign if_rvalid = if_rvalid_q;
   assign if_rdata  = if_rdata_q;
   assign d_rvalid  = d_rvalid_q;
   assign d_rdata   = d_rdata_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         owner_d_q   <= 1'b0;
         starve_q    <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_we_q    <= 1'b0;
         if_rvalid_q <= 1'b0;
         d_rvalid_q  <= 1'b0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
      end else begin
         if_rvalid_q <= 1'b0;
         d_rvalid_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               // Counter only tracks data wins taken while fetch was actually waiting.
               if (!if_req || if_gnt) begin
                  starve_q <= '0;
               end else if (d_gnt && (starve_q != CW'(STARVE_LIMIT))) begin
                  starve_q <= starve_q + CW'(1);
               end
               if (if_gnt || d_gnt) begin
                  state_q    <= BUSY;
                  owner_d_q  <= d_gnt;
                  mem_addr_q <= d_gnt ? d_addr : if_addr;
                  mem_we_q   <= d_gnt && d_we;
                  if (d_gnt) begin
                     mem_wdata_q <= d_wdata;
                  end
               end
            end
            BUSY: begin
               if (mem_ready) begin
                  state_q <= IDLE;
                  if (owner_d_q) begin
                     d_rvalid_q <= 1'b1;
                     d_rdata_q  <= mem_we_q ? '0 : mem_rdata;
                  end else begin
                     if_rvalid_q <= 1'b1;
                     if_rdata_q  <= mem_rdata;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_qar_mem_arbiter.sv
// Directed self-checking bench for qar_mem_arbiter (STARVE_LIMIT = 4).
module tb_qar_mem_arbiter;
   logic        clk;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt;
   logic        if_rvalid;
   logic [31:0] if_rdata;
   logic        d_req;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_we;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;
   logic        mem_valid;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_we;
   logic        mem_ready;
   logic [31:0] mem_rdata;

   int n_tests;
   int n_fail;

   qar_mem_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_gnt    (if_gnt),
      .if_rvalid (if_rvalid),
      .if_rdata  (if_rdata),
      .d_req     (d_req),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_we      (d_we),
      .d_gnt     (d_gnt),
      .d_rvalid  (d_rvalid),
      .d_rdata   (d_rdata),
      .mem_valid (mem_valid),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_we    (mem_we),
      .mem_ready (mem_ready),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Inputs change just after the rising edge; outputs are sampled on the falling edge.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      clk       = 1'b0;
      rst       = 1'b1;
      if_req    = 1'b1;
      if_addr   = 32'h0;
      d_req     = 1'b1;
      d_addr    = 32'h0;
      d_wdata   = 32'h0;
      d_we      = 1'b0;
      mem_ready = 1'b0;
      mem_rdata = 32'h0;

      // Reset state; grants held low while in reset even with requests pending
      next_cycle();
      next_cycle();
      sample();
      check("rst_if_gnt", 32'(if_gnt), 32'd0);
      check("rst_d_gnt", 32'(d_gnt), 32'd0);
      check("rst_mem_valid", 32'(mem_valid), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_mem_wdata", mem_wdata, 32'h0);
      check("rst_rvalid", 32'({if_rvalid, d_rvalid}), 32'd0);
      check("rst_rdata", if_rdata | d_rdata, 32'h0);
      next_cycle();
      rst    = 1'b0;
      if_req = 1'b0;
      d_req  = 1'b0;
      next_cycle();

      // Single fetch, memory ready two cycles after grant
      if_req  = 1'b1;
      if_addr = 32'h100;
      sample();
      check("f1_if_gnt_t0", 32'(if_gnt), 32'd1);
      check("f1_d_gnt_t0", 32'(d_gnt), 32'd0);
      next_cycle();
      if_req = 1'b0;
      sample();
      check("f1_mem_valid_t1", 32'(mem_valid), 32'd1);
      check("f1_mem_addr_t1", mem_addr, 32'h100);
      check("f1_mem_we_t1", 32'(mem_we), 32'd0);
      check("f1_if_gnt_busy", 32'(if_gnt), 32'd0);
      next_cycle();
      mem_ready = 1'b1;
      mem_rdata = 32'hDEADBEEF;
      sample();
      check("f1_mem_valid_t2", 32'(mem_valid), 32'd1);
      check("f1_mem_addr_t2", mem_addr, 32'h100);
      check("f1_rvalid_t2", 32'(if_rvalid), 32'd0);
      next_cycle();
      mem_ready = 1'b0;
      sample();
      check("f1_rvalid_t3", 32'(if_rvalid), 32'd1);
      check("f1_rdata_t3", if_rdata, 32'hDEADBEEF);
      check("f1_d_rvalid_t3", 32'(d_rvalid), 32'd0);
      check("f1_mem_valid_t3", 32'(mem_valid), 32'd0);
      next_cycle();
      sample();
      check("f1_rvalid_t4", 32'(if_rvalid), 32'd0);
      check("f1_rdata_hold", if_rdata, 32'hDEADBEEF);
      next_cycle();

      // Simultaneous requests, memory always ready: data first, then fetch
      mem_ready = 1'b1;
      mem_rdata = 32'hA5A50001;
      if_req    = 1'b1;
      if_addr   = 32'h300;
      d_req     = 1'b1;
      d_we      = 1'b0;
      d_addr    = 32'h200;
      sample();
      check("sim_d_gnt_t0", 32'(d_gnt), 32'd1);
      check("sim_if_gnt_t0", 32'(if_gnt), 32'd0);
      next_cycle();
      d_req = 1'b0;
      sample();
      check("sim_mem_addr_t1", mem_addr, 32'h200);
      check("sim_if_gnt_t1", 32'(if_gnt), 32'd0);
      next_cycle();
      sample();
      check("sim_d_rvalid_t2", 32'(d_rvalid), 32'd1);
      check("sim_d_rdata_t2", d_rdata, 32'hA5A50001);
      check("sim_if_gnt_t2", 32'(if_gnt), 32'd1);
      next_cycle();
      if_req    = 1'b0;
      mem_rdata = 32'h00001111;
      sample();
      check("sim_mem_addr_t3", mem_addr, 32'h300);
      check("sim_if_rvalid_t3", 32'(if_rvalid), 32'd0);
      check("sim_d_rvalid_t3", 32'(d_rvalid), 32'd0);
      next_cycle();
      sample();
      check("sim_if_rvalid_t4", 32'(if_rvalid), 32'd1);
      check("sim_if_rdata_t4", if_rdata, 32'h00001111);
      check("sim_d_rdata_hold", d_rdata, 32'hA5A50001);
      next_cycle();

      // Starvation: both ports hammer; every fifth grant goes to fetch
      if_req  = 1'b1;
      if_addr = 32'h400;
      d_req   = 1'b1;
      d_addr  = 32'h800;
      for (int i = 0; i < 10; i++) begin
         sample();
         check($sformatf("stv_if_gnt_%0d", i), 32'(if_gnt), ((i % 5) == 4) ? 32'd1 : 32'd0);
         check($sformatf("stv_d_gnt_%0d", i), 32'(d_gnt), ((i % 5) == 4) ? 32'd0 : 32'd1);
         next_cycle();
         sample();
         check($sformatf("stv_addr_%0d", i), mem_addr, ((i % 5) == 4) ? 32'h400 : 32'h800);
         next_cycle();
      end
      if_req    = 1'b0;
      d_req     = 1'b0;
      mem_ready = 1'b0;
      next_cycle();
      next_cycle();

      // Write with memory ready on the third busy cycle
      mem_rdata = 32'hFFFFFFFF;
      d_req     = 1'b1;
      d_we      = 1'b1;
      d_addr    = 32'h40;
      d_wdata   = 32'h12345678;
      sample();
      check("wr_d_gnt", 32'(d_gnt), 32'd1);
      next_cycle();
      d_req   = 1'b0;
      d_we    = 1'b0;
      d_wdata = 32'h0;
      for (int i = 1; i <= 3; i++) begin
         if (i == 3) mem_ready = 1'b1;
         sample();
         check($sformatf("wr_mem_valid_t%0d", i), 32'(mem_valid), 32'd1);
         check($sformatf("wr_mem_we_t%0d", i), 32'(mem_we), 32'd1);
         check($sformatf("wr_mem_wdata_t%0d", i), mem_wdata, 32'h12345678);
         check($sformatf("wr_mem_addr_t%0d", i), mem_addr, 32'h40);
         check($sformatf("wr_rvalid_t%0d", i), 32'({if_rvalid, d_rvalid}), 32'd0);
         next_cycle();
      end
      mem_ready = 1'b0;
      sample();
      check("wr_d_rvalid", 32'(d_rvalid), 32'd1);
      check("wr_d_rdata", d_rdata, 32'h0);
      check("wr_if_rvalid", 32'(if_rvalid), 32'd0);
      check("wr_if_rdata_hold", if_rdata, 32'h00001111);
      next_cycle();
      sample();
      check("wr_d_rvalid_end", 32'(d_rvalid), 32'd0);
      next_cycle();

      // Reset while busy abandons the transaction
      if_req  = 1'b1;
      if_addr = 32'h500;
      sample();
      check("rm_if_gnt", 32'(if_gnt), 32'd1);
      next_cycle();
      if_req = 1'b0;
      rst    = 1'b1;
      sample();
      check("rm_busy_valid", 32'(mem_valid), 32'd1);
      next_cycle();
      rst       = 1'b0;
      mem_ready = 1'b1;
      mem_rdata = 32'h00000BAD;
      sample();
      check("rm_mem_valid_after", 32'(mem_valid), 32'd0);
      check("rm_rvalid_after", 32'({if_rvalid, d_rvalid}), 32'd0);
      check("rm_rdata_cleared", if_rdata | d_rdata, 32'h0);
      next_cycle();
      mem_ready = 1'b0;
      sample();
      check("rm_rvalid_late", 32'({if_rvalid, d_rvalid}), 32'd0);
      next_cycle();
      if_req  = 1'b1;
      if_addr = 32'h600;
      sample();
      check("rm_regrant", 32'(if_gnt), 32'd1);
      next_cycle();
      if_req    = 1'b0;
      mem_ready = 1'b1;
      mem_rdata = 32'h00600600;
      sample();
      check("rm_regrant_addr", mem_addr, 32'h600);
      next_cycle();
      mem_ready = 1'b0;
      sample();
      check("rm_regrant_rvalid", 32'(if_rvalid), 32'd1);
      check("rm_regrant_rdata", if_rdata, 32'h00600600);
      next_cycle();

      // Stray mem_ready in idle is ignored
      mem_ready = 1'b1;
      mem_rdata = 32'hCAFEF00D;
      for (int i = 0; i < 3; i++) begin
         sample();
         check($sformatf("stray_mem_valid_%0d", i), 32'(mem_valid), 32'd0);
         check($sformatf("stray_rvalid_%0d", i), 32'({if_rvalid, d_rvalid}), 32'd0);
         next_cycle();
      end
      mem_ready = 1'b0;
      sample();
      check("stray_rvalid_end", 32'({if_rvalid, d_rvalid}), 32'd0);
      check("stray_if_rdata_hold", if_rdata, 32'h00600600);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
